// File: rtl/alu_ctrl.sv
// Command sequencer in front of a combinational ALU: it keeps the accumulator as operand A,
// latches operand B and the select, and returns accumulator snapshots over a result channel.
module alu_ctrl #(
    parameter int unsigned WIDTH = 20,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             err,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {StIdle, StExec, StOut} state_e;

    localparam logic [2:0] OpLoad = 3'b000;
    localparam logic [2:0] OpAnd  = 3'b001;
    localparam logic [2:0] OpXor  = 3'b010;
    localparam logic [2:0] OpOr   = 3'b011;
    localparam logic [2:0] OpAdd  = 3'b100;
    localparam logic [2:0] OpRead = 3'b101;

    state_e           state_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] b_q;
    logic             cmd_accept;
    logic             is_alu_op;
    logic [1:0]       sel_dec;

    assign alu_a      = acc_q;
    assign alu_b      = b_q;
    // cmd_ready is only ever high in StIdle, so this also qualifies the state.
    assign cmd_accept = cmd_valid && cmd_ready;

    always_comb begin
        is_alu_op = 1'b1;
        sel_dec   = 2'b00;
        unique case (cmd_op)
            OpAnd:   sel_dec = 2'b00;
            OpXor:   sel_dec = 2'b01;
            OpOr:    sel_dec = 2'b10;
            OpAdd:   sel_dec = 2'b11;
            default: is_alu_op = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            acc_q     <= '0;
            b_q       <= '0;
            alu_sel   <= 2'b00;
            res_data  <= '0;
            res_valid <= 1'b0;
            err       <= 1'b0;
            op_count  <= '0;
            cmd_ready <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    cmd_ready <= 1'b1;
                    if (cmd_accept) begin
                        if (cmd_op == OpLoad) begin
                            acc_q <= cmd_data;
                        end else if (is_alu_op) begin
                            b_q       <= cmd_data;
                            alu_sel   <= sel_dec;
                            state_q   <= StExec;
                            cmd_ready <= 1'b0;
                        end else if (cmd_op == OpRead) begin
                            res_data  <= acc_q;
                            res_valid <= 1'b1;
                            state_q   <= StOut;
                            cmd_ready <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                StExec: begin
                    acc_q <= alu_result;
                    if (op_count != '1) begin
                        op_count <= op_count + 1'b1;
                    end
                    state_q   <= StIdle;
                    cmd_ready <= 1'b1;
                end
                StOut: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state_q   <= StIdle;
                        cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    cmd_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_ctrl.sv
// Bench for alu_ctrl: directed plan plus random commands, checked against an arithmetic
// model of the accumulator, sticky error flag and saturating operation count.
module tb_alu_ctrl;

    localparam int W  = 20;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_op = 3'b000;
    logic [W-1:0]  cmd_data = '0;
    logic [W-1:0]  alu_a;
    logic [W-1:0]  alu_b;
    logic [1:0]    alu_sel;
    logic [W-1:0]  alu_result;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [W-1:0]  res_data;
    logic          err;
    logic [CW-1:0] op_count;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [W-1:0] ref_acc = '0;
    logic         ref_err = 1'b0;
    int           ref_cnt = 0;
    int           sel_tab [5] = '{0, 0, 1, 2, 3};

    always #5 clk = ~clk;

    // Stand-in for the external combinational ALU.
    always_comb begin
        alu_result = '0;
        case (alu_sel)
            2'b00: alu_result = alu_a & alu_b;
            2'b01: alu_result = alu_a ^ alu_b;
            2'b10: alu_result = alu_a | alu_b;
            2'b11: alu_result = alu_a + alu_b;
            default: alu_result = '0;
        endcase
    end

    alu_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_result (alu_result),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .err        (err),
        .op_count   (op_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_alu(input logic [2:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        int unsigned s;
        case (op)
            3'd1: return a & b;
            3'd2: return a ^ b;
            3'd3: return a | b;
            3'd4: begin
                s = 32'(a) + 32'(b);
                return W'(s % (32'd1 << W));
            end
            default: return a;
        endcase
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_alu_a"}, alu_a, 0);
        check({tag, "_alu_b"}, alu_b, 0);
        check({tag, "_alu_sel"}, alu_sel, 0);
        check({tag, "_res_data"}, res_data, 0);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_op_count"}, op_count, 0);
        check({tag, "_cmd_ready"}, cmd_ready, 0);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("cmd_ready_wait", cmd_ready, 1);
    endtask

    task automatic do_cmd(input logic [2:0] op, input logic [W-1:0] data);
        wait_ready();
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_data  = W'($urandom);
        if (op == 3'd0) begin
            ref_acc = data;
            check("load_acc", alu_a, ref_acc);
            check("load_ready", cmd_ready, 1);
        end else if (op >= 3'd1 && op <= 3'd4) begin
            check("exec_sel", alu_sel, sel_tab[op]);
            check("exec_b", alu_b, data);
            check("exec_ready", cmd_ready, 0);
            ref_acc = ref_alu(op, ref_acc, data);
            if (ref_cnt < 255) ref_cnt++;
            @(posedge clk); #1;
            check("exec_acc", alu_a, ref_acc);
            check("exec_ready_back", cmd_ready, 1);
        end else begin
            ref_err = 1'b1;
            check("illegal_acc", alu_a, ref_acc);
            check("illegal_ready", cmd_ready, 1);
        end
        check("err", err, ref_err);
        check("op_count", op_count, ref_cnt);
    endtask

    task automatic do_read(input int hold, input bit hold_valid);
        wait_ready();
        res_ready = (hold == 0);
        cmd_valid = 1'b1;
        cmd_op    = 3'd5;
        cmd_data  = W'($urandom);
        @(posedge clk); #1;
        cmd_valid = hold_valid;
        cmd_op    = 3'd0;
        cmd_data  = 20'hABCDE;
        check("rd_valid", res_valid, 1);
        check("rd_data", res_data, ref_acc);
        check("rd_busy", cmd_ready, 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", res_valid, 1);
            check("hold_data", res_data, ref_acc);
            check("hold_busy", cmd_ready, 0);
            check("hold_acc", alu_a, ref_acc);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        check("rd_done", res_valid, 0);
        check("rd_ready_back", cmd_ready, 1);
        check("rd_acc_kept", alu_a, ref_acc);
    endtask

    task automatic random_phase(input int n);
        int r;
        logic [W-1:0] d;
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 9);
            d = W'($urandom);
            if (r <= 4) do_cmd(3'(r), d);
            else if (r <= 6) do_read($urandom_range(0, 2), 1'($urandom_range(0, 1)));
            else if (r == 7) do_cmd(3'($urandom_range(6, 7)), d);
            else do_cmd(3'd4, d);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset and release
        #2;
        check_reset_vals("rst_async");
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("rst_held");
        rst_n = 1'b1;
        check("rst_release_ready", cmd_ready, 0);
        @(posedge clk); #1;
        check("first_ready", cmd_ready, 1);

        // Directed arithmetic cases
        do_cmd(3'd0, 20'h0000F);
        do_cmd(3'd4, 20'h00001);
        do_read(0, 1'b0);
        check("tp_add", res_data, 20'h00010);
        check("tp_add_cnt", op_count, 1);
        do_cmd(3'd0, 20'hFFFFF);
        do_cmd(3'd4, 20'h00002);
        do_read(0, 1'b0);
        check("tp_wrap", res_data, 20'h00001);
        do_cmd(3'd0, 20'hF0F0F);
        do_cmd(3'd1, 20'h0FF00);
        do_read(0, 1'b0);
        check("tp_and", res_data, 20'h00F00);
        do_cmd(3'd0, 20'hF0F0F);
        do_cmd(3'd2, 20'hFFFFF);
        do_read(0, 1'b0);
        check("tp_xor", res_data, 20'h0F0F0);
        do_cmd(3'd0, 20'h00000);
        do_cmd(3'd3, 20'h12345);
        do_read(0, 1'b0);
        check("tp_or", res_data, 20'h12345);

        // Back-pressured READ with a command held pending
        do_read(5, 1'b1);
        check("tp_hold_data", res_data, 20'h12345);

        // Illegal opcode is dropped but sticks in err
        do_cmd(3'd6, 20'h11111);
        check("tp_illegal_err", err, 1);
        check("tp_illegal_acc", alu_a, 20'h12345);
        check("tp_illegal_cnt", op_count, 5);
        do_cmd(3'd4, 20'h00001);
        check("tp_after_illegal_acc", alu_a, 20'h12346);
        check("tp_err_sticky", err, 1);

        random_phase(40);

        // Counter saturation
        do_cmd(3'd0, 20'h00000);
        for (int i = 0; i < 256; i++) do_cmd(3'd4, 20'h00001);
        check("tp_sat_cnt", op_count, 255);
        check("tp_sat_acc", alu_a, 20'h00100);

        // Reset in the middle of EXEC
        do_cmd(3'd0, 20'h00005);
        wait_ready();
        cmd_valid = 1'b1;
        cmd_op    = 3'd4;
        cmd_data  = 20'h00003;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("mid_exec_sel", alu_sel, 3);
        rst_n = 1'b0;
        #1;
        check_reset_vals("rst_mid_exec");
        @(posedge clk); #1;
        rst_n = 1'b1;
        ref_acc = '0;
        ref_err = 1'b0;
        ref_cnt = 0;
        check("mid_rst_release_ready", cmd_ready, 0);
        @(posedge clk); #1;
        check("mid_rst_ready", cmd_ready, 1);
        do_read(0, 1'b0);
        check("tp_rst_read", res_data, 20'h00000);

        random_phase(40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_ctrl.md
# alu_ctrl

Command-driven sequencer that sits in front of the 20-bit ALU and drives its operand and select inputs. It accepts operation commands over a valid/ready handshake and keeps a 20-bit accumulator as the ALU's A operand. Each ALU result is written back into the accumulator, and the accumulator is returned over a second valid/ready result channel on request. The block is the initiator to the ALU's combinational responder: it sequences operations that the ALU only evaluates.

## Interface
- WIDTH, 20, operand/accumulator width; matches the ALU.
- CNT_W, 8, width of the executed-operation counter.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command; registered.
- cmd_op  input  3  000 LOAD, 001 AND, 010 XOR, 011 OR, 100 ADD, 101 READ, 110/111 illegal.
- cmd_data  input  WIDTH  operand for LOAD/AND/XOR/OR/ADD; ignored for READ.
- alu_a  output  WIDTH  ALU input A; always equals the accumulator.
- alu_b  output  WIDTH  ALU input B; the latched operand register.
- alu_sel  output  2  ALU select: 00 AND, 01 XOR, 10 OR, 11 ADD; registered.
- alu_result  input  WIDTH  combinational ALU output.
- res_valid  output  1  result word present.
- res_ready  input  1  consumer accepts the result.
- res_data  output  WIDTH  accumulator snapshot taken at READ.
- err  output  1  sticky; set by an illegal opcode.
- op_count  output  CNT_W  number of executed ALU operations; saturates at all-ones.

## Operation
- States are IDLE, EXEC and OUT.
- A command is accepted on a rising edge with cmd_valid=1 and cmd_ready=1.
- cmd_ready is 1 only while the state is IDLE and is 0 in EXEC and OUT.
- IDLE, LOAD: acc ← cmd_data; state stays IDLE; no result word is produced.
- IDLE, AND/XOR/OR/ADD: b_reg ← cmd_data; alu_sel ← 00/01/10/11 respectively; state → EXEC.
- EXEC: acc ← alu_result; op_count increments unless it is already all-ones; state → IDLE.
- IDLE, READ: res_data ← acc; res_valid ← 1; state → OUT.
- OUT: hold res_valid and res_data stable until res_ready=1 on an edge. On that edge res_valid ← 0 and state → IDLE.
- Illegal opcode (110/111): the command is accepted and dropped; err ← 1; state stays IDLE; acc is unchanged.
- ADD wraps modulo 2^WIDTH; the carry is discarded.
- err clears only on reset.
- alu_sel and b_reg hold their last values outside EXEC.

## Timing
- Reset values (rst_n=0, asynchronous): state IDLE, acc=0, b_reg=0, alu_sel=00, res_data=0, res_valid=0, err=0, op_count=0, cmd_ready=0.
- cmd_ready rises on the first rising edge after rst_n deasserts.
- ALU op accepted at edge k: EXEC occupies cycle k→k+1, acc updates at edge k+1, and cmd_ready=1 again after edge k+1. Peak rate is one ALU op per 2 cycles.
- LOAD accepted at edge k: acc is valid after edge k, and cmd_ready stays 1, so back-to-back LOADs are allowed.
- READ accepted at edge k: res_valid=1 after edge k.
  - res_ready already high at edge k+1: the transfer completes at k+1 and cmd_ready=1 after k+1.
  - res_ready low: OUT holds indefinitely.
- A READ that immediately follows an ALU op returns the post-op accumulator.
- Reset asserted mid-EXEC or mid-OUT: all state returns to reset values immediately. The in-flight op is lost and no result word is emitted.
- alu_result is sampled only at the EXEC edge, and the ALU path must close in one cycle.

## Test plan
- LOAD 0x0000F, ADD 0x00001, READ with res_ready=1 → res_data=0x00010, op_count=1, and alu_sel=11 during EXEC.
- LOAD 0xFFFFF, ADD 0x00002, READ → res_data=0x00001 (wrap-around); LOAD 0xF0F0F, AND 0x0FF00, READ → 0x00F00; LOAD 0xF0F0F, XOR 0xFFFFF, READ → 0x0F0F0; LOAD 0x00000, OR 0x12345, READ → 0x12345.
- READ with res_ready=0 for 5 cycles and cmd_valid held high → res_valid and res_data stay stable and cmd_ready=0 throughout. Raising res_ready completes the transfer in 1 cycle, then cmd_ready=1.
- cmd_op=110 with data 0x11111 → err=1, acc unchanged, op_count unchanged. A following legal ADD still executes, and err stays 1.
- Issue 256 ADD 0x00001 commands → op_count=255 (saturated) and acc=0x00100.
- rst_n pulsed low during EXEC after LOAD 0x00005, ADD 0x00003 → all outputs at reset values and cmd_ready=0. cmd_ready rises one edge after release; a READ then returns 0x00000.
